// File: rtl/ai_pkg.sv
// Shared types and constants for the arithmetic-intensity window scheduler.
package ai_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic [31:0] Q16_ONE     = 32'h0001_0000;
    localparam logic [31:0] Q16_MAX     = 32'hFFFF_FFFF;
    localparam logic [31:0] RIDGE_Q_DEF = 32'h000A_0000;

    typedef struct packed {
        logic [31:0] intensity;
        logic        compute;
        logic        sat;
    } ai_res_t;

endpackage

// File: rtl/ai_seq_divider.sv
// Restoring divider, one quotient bit per cycle; saturates the quotient to 32 bits.
module ai_seq_divider
    import ai_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ACC_W+15:0]   dividend,
    input  logic [ACC_W-1:0]    divisor,
    output logic                done,
    output logic [31:0]         quotient,
    output logic                overflow
);

    localparam int DW = ACC_W + 16;
    localparam int CW = $clog2(DW + 1);

    logic             busy_q, busy_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    dq_q, dq_d;
    logic [ACC_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] dvs_q, dvs_d;

    logic [ACC_W:0]   rem_sh;
    logic [ACC_W-1:0] diff;
    logic             ge;

    always_comb begin
        busy_d = busy_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        dq_d   = dq_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        // dq_q shifts dividend bits out the top and quotient bits in the bottom
        rem_sh = {rem_q, dq_q[DW-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        diff   = rem_sh[ACC_W-1:0] - dvs_q;
        if (start) begin
            busy_d = 1'b1;
            zero_d = (divisor == '0);
            cnt_d  = (divisor == '0) ? CW'(1) : CW'(DW);
            dq_d   = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
            if (!zero_q) begin
                rem_d = ge ? diff : rem_sh[ACC_W-1:0];
                dq_d  = {dq_q[DW-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            dq_q   <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done     = busy_q && (cnt_q == CW'(1));
    assign overflow = !zero_q && (|dq_q[DW-1:32]);
    assign quotient = (zero_q || overflow) ? Q16_MAX : dq_q[31:0];

endmodule

// File: rtl/ai_window_scheduler.sv
// Round-robin sample arbiter and window FSM feeding a shared FLOP/byte divider.
module ai_window_scheduler
    import ai_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter int          WIN_CYCLES = 1024,
    parameter logic [31:0] RIDGE_Q    = RIDGE_Q_DEF,
    parameter int          ACC_W      = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    input  logic [NUM_SRC*32-1:0] src_flops,
    input  logic [NUM_SRC*32-1:0] src_bytes,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_intensity,
    output logic                  res_compute,
    output logic                  res_sat,
    output logic                  busy
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int WCW   = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WCW-1:0]   win_q, win_d;
    logic [ACC_W-1:0] flop_acc_q, flop_acc_d;
    logic [ACC_W-1:0] byte_acc_q, byte_acc_d;
    logic             sat_q, sat_d;

    logic             gnt_vld;
    logic [PTR_W-1:0] gnt_idx;
    int               idx;
    logic [31:0]      s_flops, s_bytes;
    logic [ACC_W:0]   flop_sum, byte_sum;
    logic [ACC_W-1:0] flop_nxt, byte_nxt;
    logic             sat_add;

    logic             div_start, div_done, div_ovf;
    logic [31:0]      div_quo;
    ai_res_t          res;

    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (state_q == ACCUM) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                if (src_valid[PTR_W'(idx)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
        end
    end

    assign src_ready = gnt_vld ? (NUM_SRC'(1) << gnt_idx) : '0;
    assign s_flops   = src_flops[32*gnt_idx +: 32];
    assign s_bytes   = src_bytes[32*gnt_idx +: 32];

    always_comb begin
        flop_sum = {1'b0, flop_acc_q} + (ACC_W+1)'(s_flops);
        byte_sum = {1'b0, byte_acc_q} + (ACC_W+1)'(s_bytes);
        flop_nxt = flop_acc_q;
        byte_nxt = byte_acc_q;
        sat_add  = 1'b0;
        if (gnt_vld) begin
            flop_nxt = flop_sum[ACC_W] ? '1 : flop_sum[ACC_W-1:0];
            byte_nxt = byte_sum[ACC_W] ? '1 : byte_sum[ACC_W-1:0];
            sat_add  = flop_sum[ACC_W] | byte_sum[ACC_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        flop_acc_d = flop_acc_q;
        byte_acc_d = byte_acc_q;
        sat_d      = sat_q;
        div_start  = 1'b0;
        if (gnt_vld)
            ptr_d = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
        case (state_q)
            IDLE: begin
                win_d = '0;
                if (enable) begin
                    state_d = ACCUM;
                    sat_d   = 1'b0;
                end
            end
            ACCUM: begin
                flop_acc_d = flop_nxt;
                byte_acc_d = byte_nxt;
                sat_d      = sat_q | sat_add;
                win_d      = win_q + WCW'(1);
                if (!enable) begin
                    state_d    = IDLE;
                    win_d      = '0;
                    flop_acc_d = '0;
                    byte_acc_d = '0;
                    sat_d      = 1'b0;
                end else if (win_q == WCW'(WIN_CYCLES - 1)) begin
                    // The divider snapshots flop_nxt/byte_nxt; live accumulators restart.
                    state_d    = DIVIDE;
                    div_start  = 1'b1;
                    win_d      = '0;
                    flop_acc_d = '0;
                    byte_acc_d = '0;
                end
            end
            DIVIDE: begin
                if (div_done) state_d = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = enable ? ACCUM : IDLE;
                    if (enable) sat_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            flop_acc_q <= '0;
            byte_acc_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            flop_acc_q <= flop_acc_d;
            byte_acc_q <= byte_acc_d;
            sat_q      <= sat_d;
        end
    end

    ai_seq_divider #(.ACC_W(ACC_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({flop_nxt, 16'b0}),
        .divisor  (byte_nxt),
        .done     (div_done),
        .quotient (div_quo),
        .overflow (div_ovf)
    );

    always_comb begin
        res.intensity = div_quo;
        res.compute   = div_quo >= RIDGE_Q;
        res.sat       = sat_q | div_ovf;
    end

    assign res_valid     = (state_q == REPORT);
    assign res_intensity = res_valid ? res.intensity : '0;
    assign res_compute   = res_valid & res.compute;
    assign res_sat       = res_valid & res.sat;
    assign busy          = (state_q != IDLE);

endmodule
